// File: rtl/axil_passthru_master.sv
// Single-transaction AXI4-Lite master: one read or write per i_start, returns data and response.
// Optional watchdog enabled by defining PASSTHRU_TIMEOUT_EN.
module axil_passthru_master #(
  parameter logic [31:0] ADDR_BASE      = 32'h0,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_start,
  input  logic        i_write,
  input  logic [11:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_resp,
  output logic        o_timeout,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  output logic [2:0]  M_AXI_AWPROT,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY,
  output logic [31:0] M_AXI_ARADDR,
  output logic        M_AXI_ARVALID,
  output logic [2:0]  M_AXI_ARPROT,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY
);

  typedef enum logic [2:0] {StIdle, StWrReq, StWrResp, StRdReq, StRdResp} state_e;

  state_e      state_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [1:0]  resp_q;
  logic        busy_q, done_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef PASSTHRU_TIMEOUT_EN
  logic [31:0] tmo_cnt_q;
  logic        timeout_q;
  logic        resp_hs;
  // A response landing on the watchdog edge still completes normally.
  assign resp_hs = (state_q == StWrResp && M_AXI_BVALID) || (state_q == StRdResp && M_AXI_RVALID);
  assign o_timeout = timeout_q;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      resp_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
`ifdef PASSTHRU_TIMEOUT_EN
      tmo_cnt_q <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_start) begin
            addr_q  <= ADDR_BASE + {20'h0, i_addr};
            wdata_q <= i_wdata;
            busy_q  <= 1'b1;
`ifdef PASSTHRU_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
            if (i_write) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrReq;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= StRdReq;
            end
          end
        end
        StWrReq: begin
          if (awvalid_q && M_AXI_AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && M_AXI_WREADY) wvalid_q <= 1'b0;
          // Each channel is finished if it already handshook or handshakes on this edge.
          if ((!awvalid_q || M_AXI_AWREADY) && (!wvalid_q || M_AXI_WREADY)) begin
            bready_q <= 1'b1;
            state_q  <= StWrResp;
          end
        end
        StWrResp: begin
          if (M_AXI_BVALID) begin
            bready_q <= 1'b0;
            resp_q   <= M_AXI_BRESP;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        StRdReq: begin
          if (M_AXI_ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= StRdResp;
          end
        end
        StRdResp: begin
          if (M_AXI_RVALID) begin
            rready_q <= 1'b0;
            rdata_q  <= M_AXI_RDATA;
            resp_q   <= M_AXI_RRESP;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
`ifdef PASSTHRU_TIMEOUT_EN
      if (state_q == StIdle) begin
        if (i_start) tmo_cnt_q <= 32'd1;
      end else begin
        tmo_cnt_q <= tmo_cnt_q + 32'd1;
        if (!resp_hs && tmo_cnt_q >= TIMEOUT_CYCLES - 1) begin
          awvalid_q <= 1'b0;
          wvalid_q  <= 1'b0;
          bready_q  <= 1'b0;
          arvalid_q <= 1'b0;
          rready_q  <= 1'b0;
          resp_q    <= 2'b11;
          timeout_q <= 1'b1;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= StIdle;
        end
      end
`endif
    end
  end

  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_rdata       = rdata_q;
  assign o_resp        = resp_q;
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = 4'hF;
  assign M_AXI_AWPROT  = 3'b000;
  assign M_AXI_ARPROT  = 3'b000;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = bready_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_axil_passthru_master.sv
// Bench for axil_passthru_master: cycle-level slave model with programmable delays,
// per-transaction latency/response expectations computed from the protocol rules.
module tb_axil_passthru_master;

  localparam logic [31:0] BASE = 32'hFFFF_FF00;
  localparam int unsigned TMO  = 20;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        i_start = 1'b0, i_write = 1'b0;
  logic [11:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic        o_busy, o_done, o_timeout;
  logic [31:0] o_rdata;
  logic [1:0]  o_resp;
  logic [31:0] M_AXI_AWADDR, M_AXI_WDATA, M_AXI_ARADDR;
  logic [2:0]  M_AXI_AWPROT, M_AXI_ARPROT;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY;
  logic        M_AXI_AWREADY = 1'b0, M_AXI_WREADY = 1'b0, M_AXI_ARREADY = 1'b0;
  logic        M_AXI_BVALID = 1'b0, M_AXI_RVALID = 1'b0;
  logic [1:0]  M_AXI_BRESP = '0, M_AXI_RRESP = '0;
  logic [31:0] M_AXI_RDATA = '0;

  always #5 clk = ~clk;

  axil_passthru_master #(.ADDR_BASE(BASE), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetn(resetn), .i_start(i_start), .i_write(i_write), .i_addr(i_addr),
    .i_wdata(i_wdata), .o_busy(o_busy), .o_done(o_done), .o_rdata(o_rdata), .o_resp(o_resp),
    .o_timeout(o_timeout),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWPROT(M_AXI_AWPROT),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB),
    .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY), .M_AXI_ARADDR(M_AXI_ARADDR),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARPROT(M_AXI_ARPROT), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP), .M_AXI_RVALID(M_AXI_RVALID),
    .M_AXI_RREADY(M_AXI_RREADY)
  );

  int n_checks = 0, n_fail = 0;
  logic [31:0] model_rdata = '0;

  // Observations of the most recent run_txn call.
  int r_done, r_ndone, r_aw, r_w, r_ar, r_b, r_r, r_viol;
  int r_last_aw, r_last_w, r_last_ar, r_first_br, r_rst_ok;
  logic r_rdy_at_done;
  logic [31:0] r_awaddr, r_wdata, r_araddr;

  // Cycle 1 is the cycle after the start edge; the slave drives inputs at each negedge.
  task automatic run_txn(input bit wr, input logic [11:0] addr, input logic [31:0] wdata,
                         input int aw_dly, input int w_dly, input int ar_dly, input int rsp_dly,
                         input logic [31:0] rdata, input logic [1:0] resp,
                         input int extra_start, input int rst_cycle, input int budget);
    int aw_c = 0, w_c = 0, ar_c = 0, b_c = 0, r_c = 0, stop_at = budget;
    bit aw_p = 0, w_p = 0, ar_p = 0, aw_f = 0, w_f = 0, ar_f = 0, busy_exp;
    logic [31:0] aw_h = '0, w_h = '0, ar_h = '0;
    r_done = -1; r_ndone = 0; r_aw = 0; r_w = 0; r_ar = 0; r_b = 0; r_r = 0; r_viol = 0;
    r_last_aw = -1; r_last_w = -1; r_last_ar = -1; r_first_br = -1; r_rst_ok = -1;
    r_rdy_at_done = 1'b1; r_awaddr = '0; r_wdata = '0; r_araddr = '0;
    @(negedge clk);
    i_start = 1'b1; i_write = wr; i_addr = addr; i_wdata = wdata;
    for (int c = 1; c <= stop_at; c++) begin
      @(negedge clk);
      i_start = 1'b0;
      resetn  = 1'b1;
      if (rst_cycle > 0 && c == rst_cycle + 1)
        r_rst_ok = ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID, M_AXI_BREADY, M_AXI_RREADY,
                     o_busy, o_done} == 7'b0 && o_rdata == 0 && o_resp == 0 &&
                    M_AXI_AWADDR == 0 && M_AXI_WDATA == 0) ? 1 : 0;
      if (o_done) begin
        r_ndone++;
        if (r_done < 0) begin
          r_done = c; r_rdy_at_done = M_AXI_BREADY | M_AXI_RREADY; stop_at = c + 2;
        end
      end
      busy_exp = (r_done < 0) && !(rst_cycle > 0 && c > rst_cycle);
      if (o_busy !== busy_exp) r_viol++;
      if (M_AXI_WSTRB !== 4'hF || M_AXI_AWPROT !== 3'b0 || M_AXI_ARPROT !== 3'b0) r_viol++;
      if ((M_AXI_BREADY || M_AXI_RREADY) && (M_AXI_AWVALID || M_AXI_WVALID || M_AXI_ARVALID))
        r_viol++;
      if (M_AXI_BREADY && !(aw_f && w_f)) r_viol++;
      if (M_AXI_RREADY && !ar_f) r_viol++;
      if (aw_p && (!M_AXI_AWVALID || M_AXI_AWADDR !== aw_h)) r_viol++;
      if (w_p && (!M_AXI_WVALID || M_AXI_WDATA !== w_h)) r_viol++;
      if (ar_p && (!M_AXI_ARVALID || M_AXI_ARADDR !== ar_h)) r_viol++;
      if ((M_AXI_AWVALID && aw_f) || (M_AXI_WVALID && w_f) || (M_AXI_ARVALID && ar_f)) r_viol++;
      if (M_AXI_AWVALID) r_last_aw = c;
      if (M_AXI_WVALID) r_last_w = c;
      if (M_AXI_ARVALID) r_last_ar = c;
      if (M_AXI_BREADY && r_first_br < 0) r_first_br = c;
      if (c == rst_cycle) begin
        resetn = 1'b0; stop_at = c + 3;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0; M_AXI_RVALID = 0;
        aw_p = 0; w_p = 0; ar_p = 0;
      end else begin
        M_AXI_AWREADY = M_AXI_AWVALID && aw_c >= aw_dly;
        M_AXI_WREADY  = M_AXI_WVALID && w_c >= w_dly;
        M_AXI_ARREADY = M_AXI_ARVALID && ar_c >= ar_dly;
        if (M_AXI_AWVALID) aw_c++;
        if (M_AXI_WVALID) w_c++;
        if (M_AXI_ARVALID) ar_c++;
        aw_p = M_AXI_AWVALID && !M_AXI_AWREADY; aw_h = M_AXI_AWADDR;
        w_p  = M_AXI_WVALID && !M_AXI_WREADY;   w_h  = M_AXI_WDATA;
        ar_p = M_AXI_ARVALID && !M_AXI_ARREADY; ar_h = M_AXI_ARADDR;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin r_aw++; r_awaddr = M_AXI_AWADDR; aw_f = 1; end
        if (M_AXI_WVALID && M_AXI_WREADY) begin r_w++; r_wdata = M_AXI_WDATA; w_f = 1; end
        if (M_AXI_ARVALID && M_AXI_ARREADY) begin r_ar++; r_araddr = M_AXI_ARADDR; ar_f = 1; end
        M_AXI_BVALID = M_AXI_BREADY && b_c > rsp_dly;
        M_AXI_RVALID = M_AXI_RREADY && r_c > rsp_dly;
        if (M_AXI_BREADY) b_c++;
        if (M_AXI_RREADY) r_c++;
        M_AXI_BRESP = M_AXI_BVALID ? resp : 2'($urandom);
        M_AXI_RRESP = M_AXI_RVALID ? resp : 2'($urandom);
        M_AXI_RDATA = M_AXI_RVALID ? rdata : $urandom;
        if (M_AXI_BVALID && M_AXI_BREADY) r_b++;
        if (M_AXI_RVALID && M_AXI_RREADY) r_r++;
      end
      if (c == extra_start) begin
        i_start = 1'b1; i_write = 1'($urandom); i_addr = 12'($urandom); i_wdata = $urandom;
      end
    end
    M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_ARREADY = 0; M_AXI_BVALID = 0; M_AXI_RVALID = 0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY} !== 5'b0) begin
      n_fail++; $display("FAIL reset_valid_ready: got %b want 00000",
        {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID, M_AXI_RREADY});
    end
    n_checks++;
    if ({o_busy, o_done, o_timeout, o_resp} !== 5'b0 || o_rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_status: busy/done/tmo/resp=%b rdata=%h want 0",
        {o_busy, o_done, o_timeout, o_resp}, o_rdata);
    end
    n_checks++;
    if (M_AXI_AWADDR !== 32'h0 || M_AXI_ARADDR !== 32'h0 || M_AXI_WDATA !== 32'h0) begin
      n_fail++; $display("FAIL reset_addr_data: aw=%h ar=%h wd=%h want 0",
        M_AXI_AWADDR, M_AXI_ARADDR, M_AXI_WDATA);
    end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_delayed();
    run_txn(0, 12'hFFC, $urandom, 0, 0, 3, 0, 32'hDEAD_BEEF, 2'b10, -1, -1, 40);
    model_rdata = 32'hDEAD_BEEF;
    n_checks++; if (r_last_ar !== 4) begin n_fail++;
      $display("FAIL rd_arvalid_last: got %0d want 4", r_last_ar); end
    n_checks++; if (r_araddr !== BASE + 32'hFFC) begin n_fail++;
      $display("FAIL rd_araddr: got %h want %h", r_araddr, BASE + 32'hFFC); end
    n_checks++; if (r_ar !== 1 || r_ndone !== 1) begin n_fail++;
      $display("FAIL rd_counts: ar=%0d done=%0d want 1/1", r_ar, r_ndone); end
    n_checks++; if (o_rdata !== 32'hDEAD_BEEF || o_resp !== 2'b10) begin n_fail++;
      $display("FAIL rd_result: rdata=%h resp=%b want deadbeef/10", o_rdata, o_resp); end
    n_checks++; if (r_done !== 7 || r_viol !== 0) begin n_fail++;
      $display("FAIL rd_timing: done=%0d viol=%0d want 7/0", r_done, r_viol); end
  endtask

  task automatic test_write_basic();
    run_txn(1, 12'h104, 32'hA5A5_0001, 0, 0, 0, 0, $urandom, 2'b00, -1, -1, 30);
    n_checks++; if (r_done !== 4) begin n_fail++;
      $display("FAIL wr_latency: got %0d want 4", r_done); end
    n_checks++; if (r_awaddr !== BASE + 32'h104) begin n_fail++;
      $display("FAIL wr_awaddr: got %h want %h", r_awaddr, BASE + 32'h104); end
    n_checks++; if (r_wdata !== 32'hA5A5_0001 || r_w !== 1 || r_aw !== 1) begin n_fail++;
      $display("FAIL wr_data: wdata=%h w=%0d aw=%0d want a5a50001/1/1", r_wdata, r_w, r_aw); end
    n_checks++; if (o_resp !== 2'b00 || o_rdata !== model_rdata) begin n_fail++;
      $display("FAIL wr_result: resp=%b rdata=%h want 00/%h", o_resp, o_rdata, model_rdata); end
    n_checks++; if (r_viol !== 0 || r_ndone !== 1) begin n_fail++;
      $display("FAIL wr_protocol: viol=%0d done=%0d want 0/1", r_viol, r_ndone); end
  endtask

  task automatic test_write_split();
    run_txn(1, 12'($urandom), $urandom, 0, 4, 0, 0, $urandom, 2'b01, -1, -1, 40);
    n_checks++; if (r_last_aw !== 1 || r_last_w !== 5) begin n_fail++;
      $display("FAIL split_valids: aw_last=%0d w_last=%0d want 1/5", r_last_aw, r_last_w); end
    n_checks++; if (r_first_br !== 6) begin n_fail++;
      $display("FAIL split_bready: got %0d want 6", r_first_br); end
    n_checks++; if (r_done !== 8 || o_resp !== 2'b01 || r_viol !== 0) begin n_fail++;
      $display("FAIL split_done: done=%0d resp=%b viol=%0d want 8/01/0", r_done, o_resp, r_viol);
    end
  endtask

  task automatic test_start_ignored();
    run_txn(0, 12'h010, $urandom, 0, 0, 3, 1, 32'h1234_5678, 2'b00, 2, -1, 40);
    model_rdata = 32'h1234_5678;
    n_checks++; if (r_ar !== 1 || r_aw !== 0 || r_ndone !== 1) begin n_fail++;
      $display("FAIL busy_start: ar=%0d aw=%0d done=%0d want 1/0/1", r_ar, r_aw, r_ndone); end
    n_checks++; if (r_done !== 8 || o_rdata !== model_rdata || r_viol !== 0) begin n_fail++;
      $display("FAIL busy_start_result: done=%0d rdata=%h viol=%0d want 8/%h/0",
        r_done, o_rdata, r_viol, model_rdata); end
  endtask

  task automatic test_reset_mid();
    run_txn(1, 12'h020, $urandom, 0, 10, 0, 0, $urandom, 2'b00, -1, 3, 40);
    model_rdata = '0;
    n_checks++; if (r_rst_ok !== 1) begin n_fail++;
      $display("FAIL midreset_outputs: got %0d want 1", r_rst_ok); end
    n_checks++; if (r_ndone !== 0 || r_viol !== 0) begin n_fail++;
      $display("FAIL midreset_done: done=%0d viol=%0d want 0/0", r_ndone, r_viol); end
    run_txn(0, 12'h030, $urandom, 0, 0, 1, 0, 32'hCAFE_0030, 2'b01, -1, -1, 40);
    model_rdata = 32'hCAFE_0030;
    n_checks++; if (r_done !== 5 || o_rdata !== model_rdata || o_resp !== 2'b01) begin n_fail++;
      $display("FAIL midreset_next: done=%0d rdata=%h resp=%b want 5/%h/01",
        r_done, o_rdata, o_resp, model_rdata); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      bit wr = 1'($urandom);
      logic [11:0] a = 12'($urandom);
      logic [31:0] wd = $urandom, rd = $urandom;
      logic [1:0] rs = 2'($urandom);
      int da = $urandom_range(3, 0), dw = $urandom_range(3, 0);
      int dr = $urandom_range(3, 0), dp = $urandom_range(3, 0);
      int req = wr ? ((da > dw) ? da : dw) : dr;
      int exp_done = 1 + req + 3 + dp;
      run_txn(wr, a, wd, da, dw, dr, dp, rd, rs, -1, -1, 40);
      if (!wr) model_rdata = rd;
      n_checks++;
      if (r_done !== exp_done || r_ndone !== 1 || r_viol !== 0) begin n_fail++;
        $display("FAIL rand%0d_timing: done=%0d n=%0d viol=%0d want %0d/1/0",
          i, r_done, r_ndone, r_viol, exp_done); end
      n_checks++;
      if (o_rdata !== model_rdata || o_resp !== rs || o_timeout !== 1'b0) begin n_fail++;
        $display("FAIL rand%0d_result: rdata=%h resp=%b tmo=%b want %h/%b/0",
          i, o_rdata, o_resp, o_timeout, model_rdata, rs); end
      n_checks++;
      if (wr ? (r_aw !== 1 || r_w !== 1 || r_ar !== 0 || r_awaddr !== BASE + {20'h0, a} ||
                r_wdata !== wd)
             : (r_ar !== 1 || r_aw !== 0 || r_w !== 0 || r_araddr !== BASE + {20'h0, a})) begin
        n_fail++;
        $display("FAIL rand%0d_channel: aw=%0d w=%0d ar=%0d awa=%h ara=%h wd=%h want addr %h",
          i, r_aw, r_w, r_ar, r_awaddr, r_araddr, r_wdata, BASE + {20'h0, a}); end
    end
  endtask

`ifdef PASSTHRU_TIMEOUT_EN
  task automatic test_timeout();
    run_txn(1, 12'h040, $urandom, 0, 0, 0, 1000, $urandom, 2'b00, -1, -1, 60);
    n_checks++; if (r_done !== int'(TMO) || r_ndone !== 1) begin n_fail++;
      $display("FAIL tmo_done: done=%0d n=%0d want %0d/1", r_done, r_ndone, TMO); end
    n_checks++; if (o_resp !== 2'b11 || o_timeout !== 1'b1 || o_rdata !== model_rdata) begin
      n_fail++; $display("FAIL tmo_result: resp=%b tmo=%b rdata=%h want 11/1/%h",
        o_resp, o_timeout, o_rdata, model_rdata); end
    n_checks++; if (r_rdy_at_done !== 1'b0 || M_AXI_BREADY !== 1'b0) begin n_fail++;
      $display("FAIL tmo_bready: at_done=%b now=%b want 0/0", r_rdy_at_done, M_AXI_BREADY); end
    run_txn(1, 12'h044, $urandom, 0, 0, 0, 0, $urandom, 2'b00, -1, -1, 40);
    n_checks++; if (o_timeout !== 1'b0 || r_done !== 4) begin n_fail++;
      $display("FAIL tmo_clear: tmo=%b done=%0d want 0/4", o_timeout, r_done); end
  endtask
`endif

  initial begin
    test_reset();
    test_read_delayed();
    test_write_basic();
    test_write_split();
    test_start_ignored();
    test_reset_mid();
    test_random();
`ifdef PASSTHRU_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
